// File: rtl/ss_pkg.sv
// Shared constants for the seven-segment scan capture: segment codes, BCD codes, digit slots.
// Optional range check in ss_capture is enabled by defining SS_CAPTURE_RANGE_CHECK_EN.
package ss_pkg;

    // Active-low {g,f,e,d,c,b,a} patterns
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

    localparam logic [1:0] DIG_MINS1  = 2'd0;
    localparam logic [1:0] DIG_MINS2  = 2'd1;
    localparam logic [1:0] DIG_HOURS1 = 2'd2;
    localparam logic [1:0] DIG_HOURS2 = 2'd3;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    typedef logic [3:0][3:0] digits_t;

    function automatic logic sel_legal(input logic [3:0] sel);
        return (sel == 4'b1110) || (sel == 4'b1101) ||
               (sel == 4'b1011) || (sel == 4'b0111);
    endfunction

    function automatic logic [1:0] sel_index(input logic [3:0] sel);
        logic [1:0] idx;
        case (sel)
            4'b0111: idx = DIG_HOURS2;
            4'b1011: idx = DIG_HOURS1;
            4'b1101: idx = DIG_MINS2;
            default: idx = DIG_MINS1;
        endcase
        return idx;
    endfunction

    // True when the frame is not a valid 24-hour HH:MM time (blank counts as invalid)
    function automatic logic range_bad(input digits_t d);
        return (d[DIG_HOURS2] > 4'd2) ||
               ((d[DIG_HOURS2] == 4'd2) && (d[DIG_HOURS1] > 4'd3)) ||
               (d[DIG_HOURS1] > 4'd9) ||
               (d[DIG_MINS2]  > 4'd5) ||
               (d[DIG_MINS1]  > 4'd9);
    endfunction

endpackage

// File: rtl/ss_seg_decode.sv
// Active-low seven-segment pattern to BCD; blank -> 4'hF, anything else unknown -> 4'hE.
// Purely combinational, zero latency, no flow control.
module ss_seg_decode
    import ss_pkg::*;
(
    input  logic [6:0] seg_n_i,
    output logic [3:0] bcd_o
);

    always_comb begin
        case (seg_n_i)
            SEG_0:     bcd_o = 4'd0;
            SEG_1:     bcd_o = 4'd1;
            SEG_2:     bcd_o = 4'd2;
            SEG_3:     bcd_o = 4'd3;
            SEG_4:     bcd_o = 4'd4;
            SEG_5:     bcd_o = 4'd5;
            SEG_6:     bcd_o = 4'd6;
            SEG_7:     bcd_o = 4'd7;
            SEG_8:     bcd_o = 4'd8;
            SEG_9:     bcd_o = 4'd9;
            SEG_BLANK: bcd_o = BCD_BLANK;
            default:   bcd_o = BCD_ERR;
        endcase
    end

endmodule

// File: rtl/ss_capture.sv
// Captures a multiplexed 4-digit seven-segment scan into BCD HH:MM once each digit is stable.
// Capture SETTLE+1 cycles after a digit appears; commit one cycle after the 4th capture. No backpressure.
// Define SS_CAPTURE_RANGE_CHECK_EN to reject frames that are not a valid 24-hour time.
module ss_capture
    import ss_pkg::*;
#(
    parameter int unsigned SETTLE = 4
) (
    input  logic       CLK100MHZ,
    input  logic       Reset,
    input  logic [3:0] SegmentDrivers,
    input  logic [7:0] SevenSegment,
    output logic [3:0] hours2,
    output logic [3:0] hours1,
    output logic [3:0] mins2,
    output logic [3:0] mins1,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       range_err
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    logic [11:0] s_q, s_d;
    logic [7:0]  c_q, c_d;
    state_t      state_q, state_d;
    logic [3:0]  seen_q, seen_d;
    digits_t     shadow_q, shadow_d;
    digits_t     out_q, out_d;
    logic        frame_valid_q, frame_valid_d;
    logic        seg_err_q, seg_err_d;

    logic        chg;
    logic        capture;
    logic [1:0]  cap_idx;
    logic [3:0]  dec;
    logic        frame_done;
    logic        has_err;
    logic        range_fail;

    ss_seg_decode u_decode (
        .seg_n_i (s_q[6:0]),
        .bcd_o   (dec)
    );

    // Stability tracking and capture FSM; a change always wins over a capture
    always_comb begin
        s_d     = {SegmentDrivers, SevenSegment};
        chg     = (s_d != s_q);
        c_d     = chg ? 8'd0 : ((c_q == SETTLE_C) ? c_q : c_q + 8'd1);
        state_d = state_q;
        capture = 1'b0;
        if (chg) begin
            state_d = sel_legal(s_d[11:8]) ? ST_SETTLE : ST_WAIT;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (sel_legal(s_q[11:8])) state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (c_d == SETTLE_C) begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: state_d = ST_HOLD;
                default: state_d = ST_WAIT;
            endcase
        end
    end

    assign cap_idx = sel_index(s_q[11:8]);

    // Shadow slots and frame evaluation, using the slot values as they are after this capture
    always_comb begin
        shadow_d   = shadow_q;
        seen_d     = seen_q;
        frame_done = 1'b0;
        seg_err_d  = 1'b0;
        if (capture) begin
            shadow_d[cap_idx] = dec;
            seen_d            = seen_q | (4'b0001 << cap_idx);
            seg_err_d         = (dec == BCD_ERR);
            if (seen_d == 4'hF) begin
                frame_done = 1'b1;
                seen_d     = 4'h0;
            end
        end
        has_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (shadow_d[i] == BCD_ERR) has_err = 1'b1;
        end
    end

`ifdef SS_CAPTURE_RANGE_CHECK_EN
    assign range_fail = range_bad(shadow_d);
`else
    assign range_fail = 1'b0;
`endif

    assign frame_valid_d = frame_done && !has_err && !range_fail;
    assign out_d         = frame_valid_d ? shadow_d : out_q;

    always_ff @(posedge CLK100MHZ or negedge Reset) begin
        if (!Reset) begin
            s_q           <= '1;
            c_q           <= '0;
            state_q       <= ST_WAIT;
            seen_q        <= '0;
            shadow_q      <= '0;
            out_q         <= '0;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
        end else begin
            s_q           <= s_d;
            c_q           <= c_d;
            state_q       <= state_d;
            seen_q        <= seen_d;
            shadow_q      <= shadow_d;
            out_q         <= out_d;
            frame_valid_q <= frame_valid_d;
            seg_err_q     <= seg_err_d;
        end
    end

`ifdef SS_CAPTURE_RANGE_CHECK_EN
    logic range_err_q;
    always_ff @(posedge CLK100MHZ or negedge Reset) begin
        if (!Reset) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= frame_done && !has_err && range_fail;
        end
    end
    assign range_err = range_err_q;
`else
    assign range_err = 1'b0;
`endif

    assign hours2      = out_q[DIG_HOURS2];
    assign hours1      = out_q[DIG_HOURS1];
    assign mins2       = out_q[DIG_MINS2];
    assign mins1       = out_q[DIG_MINS1];
    assign frame_valid = frame_valid_q;
    assign seg_err     = seg_err_q;

endmodule

// File: tb/tb_ss_capture.sv
// Bench for ss_capture: directed scans plus randomized dwells checked against a scan-level model.
`timescale 1ns/1ps
module tb_ss_capture;

    localparam int SETTLE = 4;
`ifdef SS_CAPTURE_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sel;
    logic [7:0] seg;
    logic [3:0] h2, h1, m2, m1;
    logic       fv, se, re;

    ss_capture #(.SETTLE(SETTLE)) dut (
        .CLK100MHZ      (clk),
        .Reset          (rst_n),
        .SegmentDrivers (sel),
        .SevenSegment   (seg),
        .hours2         (h2),
        .hours1         (h1),
        .mins2          (m2),
        .mins1          (m1),
        .frame_valid    (fv),
        .seg_err        (se),
        .range_err      (re)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Pulse monitors: count cycles each pulse output is high
    int fv_cnt = 0, se_cnt = 0, re_cnt = 0;
    always @(negedge clk) begin
        if (fv === 1'b1) fv_cnt++;
        if (se === 1'b1) se_cnt++;
        if (re === 1'b1) re_cnt++;
    end

    // Scan-level reference model
    logic [6:0]  seg_tab [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                  7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};
    logic [3:0]  m_shadow [4];
    logic [3:0]  m_out [4];
    bit   [3:0]  m_seen;
    int          m_fv = 0, m_se = 0, m_re = 0;
    logic [11:0] prev;

    function automatic logic [3:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 11; i++)
            if (p == seg_tab[i]) return (i == 10) ? 4'hF : 4'(i);
        return 4'hE;
    endfunction

    function automatic bit ref_time_bad(input logic [3:0] a, b, c, d);
        return (a > 2) || (a == 2 && b > 3) || (b > 9) || (c > 5) || (d > 9);
    endfunction

    function automatic logic [7:0] code(input int d);
        logic [6:0] p;
        p = seg_tab[d];
        return {1'b1, p};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 4'h0;
            m_out[i]    = 4'h0;
        end
        m_seen = 4'h0;
        prev   = 12'hFFF;
    endtask

    // A digit is taken once it has been presented for at least SETTLE+1 clocks
    task automatic model_dwell(input logic [3:0] s, input logic [7:0] g, input int n);
        int  idx;
        bit  bad;
        logic [3:0] v;
        case (s)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: idx = -1;
        endcase
        if (idx >= 0 && n >= SETTLE + 1) begin
            v = ref_decode(g[6:0]);
            if (v == 4'hE) m_se++;
            m_shadow[idx] = v;
            m_seen[idx]   = 1'b1;
            if (m_seen == 4'hF) begin
                m_seen = 4'h0;
                bad = 1'b0;
                for (int i = 0; i < 4; i++) if (m_shadow[i] == 4'hE) bad = 1'b1;
                if (!bad) begin
                    if (RANGE_EN && ref_time_bad(m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]))
                        m_re++;
                    else begin
                        for (int i = 0; i < 4; i++) m_out[i] = m_shadow[i];
                        m_fv++;
                    end
                end
            end
        end
    endtask

    // Present one pattern for n rising edges; returns 1ns after the following falling edge
    task automatic dwell(input logic [3:0] s, input logic [7:0] g, input int n);
        sel = s;
        seg = g;
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
        model_dwell(s, g, n);
        prev = {s, g};
    endtask

    task automatic scan4(input int d3, input int d2, input int d1, input int d0, input int n);
        dwell(4'b0111, code(d3), n);
        dwell(4'b1011, code(d2), n);
        dwell(4'b1101, code(d1), n);
        dwell(4'b1110, code(d0), n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sel   = 4'hF;
        seg   = 8'hFF;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({h2, h1, m2, m1} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_digits got=%h exp=0000", {h2, h1, m2, m1});
        end
        checks++;
        if ({fv, se, re} !== 3'b000) begin
            failures++;
            $display("FAIL reset_pulses got=%b exp=000", {fv, se, re});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan_2359();
        int f0, s0;
        f0 = fv_cnt; s0 = se_cnt;
        scan4(2, 3, 5, 9, 10);
        checks++;
        if ({h2, h1, m2, m1} !== 16'h2359) begin
            failures++;
            $display("FAIL scan2359_digits got=%h exp=2359", {h2, h1, m2, m1});
        end
        checks++;
        if (fv_cnt - f0 != 1) begin
            failures++;
            $display("FAIL scan2359_frame_valid got=%0d exp=1", fv_cnt - f0);
        end
        checks++;
        if (se_cnt - s0 != 0) begin
            failures++;
            $display("FAIL scan2359_seg_err got=%0d exp=0", se_cnt - s0);
        end
    endtask

    task automatic test_settle_boundary();
        int f0;
        f0 = fv_cnt;
        scan4(1, 2, 3, 4, SETTLE);
        checks++;
        if ({h2, h1, m2, m1} !== 16'h2359 || fv_cnt != f0) begin
            failures++;
            $display("FAIL short_dwell got=%h/%0d exp=2359/0", {h2, h1, m2, m1}, fv_cnt - f0);
        end
        scan4(1, 2, 3, 4, SETTLE + 1);
        checks++;
        if ({h2, h1, m2, m1} !== 16'h1234) begin
            failures++;
            $display("FAIL min_dwell_digits got=%h exp=1234", {h2, h1, m2, m1});
        end
        checks++;
        if (fv_cnt - f0 != 1) begin
            failures++;
            $display("FAIL min_dwell_frame_valid got=%0d exp=1", fv_cnt - f0);
        end
    endtask

    task automatic test_seg_err();
        int f0, s0;
        f0 = fv_cnt; s0 = se_cnt;
        dwell(4'b0111, code(0), 10);
        dwell(4'b1011, code(8), 10);
        dwell(4'b1101, code(1), 10);
        dwell(4'b1110, 8'h55, 10);
        checks++;
        if (se_cnt - s0 != 1) begin
            failures++;
            $display("FAIL seg_err_pulse got=%0d exp=1", se_cnt - s0);
        end
        checks++;
        if ({h2, h1, m2, m1} !== 16'h1234 || fv_cnt != f0) begin
            failures++;
            $display("FAIL seg_err_hold got=%h/%0d exp=1234/0", {h2, h1, m2, m1}, fv_cnt - f0);
        end
    endtask

    task automatic test_range();
        int f0, r0;
        f0 = fv_cnt; r0 = re_cnt;
        scan4(2, 4, 0, 0, 10);
`ifdef SS_CAPTURE_RANGE_CHECK_EN
        checks++;
        if (re_cnt - r0 != 1 || fv_cnt != f0) begin
            failures++;
            $display("FAIL range_reject got re=%0d fv=%0d exp re=1 fv=0", re_cnt - r0, fv_cnt - f0);
        end
        checks++;
        if ({h2, h1, m2, m1} !== 16'h1234) begin
            failures++;
            $display("FAIL range_hold got=%h exp=1234", {h2, h1, m2, m1});
        end
`else
        checks++;
        if (fv_cnt - f0 != 1 || re_cnt != r0) begin
            failures++;
            $display("FAIL range_commit got fv=%0d re=%0d exp fv=1 re=0", fv_cnt - f0, re_cnt - r0);
        end
        checks++;
        if ({h2, h1, m2, m1} !== 16'h2400) begin
            failures++;
            $display("FAIL range_digits got=%h exp=2400", {h2, h1, m2, m1});
        end
`endif
    endtask

    task automatic test_illegal_select();
        int f0;
        logic [15:0] held;
        f0   = fv_cnt;
        held = {h2, h1, m2, m1};
        dwell(4'b0011, code(7), 20);
        dwell(4'b1111, code(7), 20);
        dwell(4'b0111, code(1), 10);
        dwell(4'b1011, code(5), 10);
        dwell(4'b1101, code(3), 10);
        checks++;
        if (fv_cnt != f0 || {h2, h1, m2, m1} !== held) begin
            failures++;
            $display("FAIL illegal_sel_no_frame got=%h/%0d exp=%h/0", {h2, h1, m2, m1}, fv_cnt - f0, held);
        end
        dwell(4'b1110, code(0), 10);
        checks++;
        if ({h2, h1, m2, m1} !== 16'h1530 || fv_cnt - f0 != 1) begin
            failures++;
            $display("FAIL illegal_sel_then_frame got=%h/%0d exp=1530/1", {h2, h1, m2, m1}, fv_cnt - f0);
        end
    endtask

    task automatic test_reset_mid_scan();
        int f0;
        dwell(4'b0111, code(1), 10);
        dwell(4'b1011, code(9), 10);
        dwell(4'b1101, code(4), 10);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({h2, h1, m2, m1} !== 16'h0000 || {fv, se, re} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset got=%h/%b exp=0000/000", {h2, h1, m2, m1}, {fv, se, re});
        end
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        f0 = fv_cnt;
        dwell(4'b1110, code(3), 10);
        checks++;
        if (fv_cnt != f0 || {h2, h1, m2, m1} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_partial_abandoned got=%h/%0d exp=0000/0", {h2, h1, m2, m1}, fv_cnt - f0);
        end
        dwell(4'b0111, code(0), 10);
        dwell(4'b1011, code(1), 10);
        dwell(4'b1101, code(2), 10);
        checks++;
        if ({h2, h1, m2, m1} !== 16'h0123 || fv_cnt - f0 != 1) begin
            failures++;
            $display("FAIL reset_fresh_frame got=%h/%0d exp=0123/1", {h2, h1, m2, m1}, fv_cnt - f0);
        end
    endtask

    task automatic test_random();
        logic [3:0] s;
        logic [7:0] g;
        logic [6:0] p;
        int n;
        for (int k = 0; k < 300; k++) begin
            do begin
                if ($urandom_range(0, 9) < 8) begin
                    case ($urandom_range(0, 3))
                        0: s = 4'b1110;
                        1: s = 4'b1101;
                        2: s = 4'b1011;
                        default: s = 4'b0111;
                    endcase
                end else begin
                    s = 4'($urandom());
                end
                if ($urandom_range(0, 9) < 8) begin
                    p = seg_tab[$urandom_range(0, 10)];
                    g = {1'($urandom_range(0, 1)), p};
                end else begin
                    g = 8'($urandom());
                end
            end while ({s, g} == prev);
            n = $urandom_range(SETTLE - 1 < 1 ? 1 : SETTLE - 1, SETTLE + 3);
            dwell(s, g, n);
            checks++;
            if ({h2, h1, m2, m1} !== {m_out[3], m_out[2], m_out[1], m_out[0]}) begin
                failures++;
                $display("FAIL rand_digits step=%0d got=%h exp=%h", k, {h2, h1, m2, m1},
                         {m_out[3], m_out[2], m_out[1], m_out[0]});
            end
            checks++;
            if (fv_cnt != m_fv || se_cnt != m_se || re_cnt != m_re) begin
                failures++;
                $display("FAIL rand_pulses step=%0d got fv=%0d se=%0d re=%0d exp fv=%0d se=%0d re=%0d",
                         k, fv_cnt, se_cnt, re_cnt, m_fv, m_se, m_re);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_2359();
        test_settle_boundary();
        test_seg_err();
        test_range();
        test_illegal_select();
        test_reset_mid_scan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
